// File: rtl/mc_control_pkg.sv
// ============================================================================
//  Module   : mc_control_pkg
//  Purpose  : Shared opcode/funct, NPC, ALU, EXT and state encodings for the
//             multi-cycle MIPS control sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_control_pkg;

   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_j     = 6'h02;
   localparam logic [5:0] c_op_jal   = 6'h03;
   localparam logic [5:0] c_op_beq   = 6'h04;
   localparam logic [5:0] c_op_bne   = 6'h05;
   localparam logic [5:0] c_op_addiu = 6'h09;
   localparam logic [5:0] c_op_slti  = 6'h0A;
   localparam logic [5:0] c_op_ori   = 6'h0D;
   localparam logic [5:0] c_op_lui   = 6'h0F;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2B;

   localparam logic [5:0] c_fn_jr    = 6'h08;
   localparam logic [5:0] c_fn_addu  = 6'h21;
   localparam logic [5:0] c_fn_subu  = 6'h23;
   localparam logic [5:0] c_fn_and   = 6'h24;
   localparam logic [5:0] c_fn_or    = 6'h25;
   localparam logic [5:0] c_fn_xor   = 6'h26;
   localparam logic [5:0] c_fn_nor   = 6'h27;
   localparam logic [5:0] c_fn_slt   = 6'h2A;
   localparam logic [5:0] c_fn_sltu  = 6'h2B;

   localparam logic [1:0] c_npc_plus4  = 2'd0;
   localparam logic [1:0] c_npc_branch = 2'd1;
   localparam logic [1:0] c_npc_jump   = 2'd2;
   localparam logic [1:0] c_npc_jr     = 2'd3;

   localparam logic [4:0] c_alu_add  = 5'd0;
   localparam logic [4:0] c_alu_sub  = 5'd1;
   localparam logic [4:0] c_alu_and  = 5'd2;
   localparam logic [4:0] c_alu_or   = 5'd3;
   localparam logic [4:0] c_alu_xor  = 5'd4;
   localparam logic [4:0] c_alu_nor  = 5'd5;
   localparam logic [4:0] c_alu_slt  = 5'd6;
   localparam logic [4:0] c_alu_sltu = 5'd7;
   localparam logic [4:0] c_alu_lui  = 5'd8;

   localparam logic [1:0] c_ext_zero = 2'd0;
   localparam logic [1:0] c_ext_sign = 2'd1;
   localparam logic [1:0] c_ext_lui  = 2'd2;

   localparam logic [1:0] c_dst_rt  = 2'd0;
   localparam logic [1:0] c_dst_rd  = 2'd1;
   localparam logic [1:0] c_dst_r31 = 2'd2;

   localparam logic [1:0] c_wd_alu = 2'd0;
   localparam logic [1:0] c_wd_mem = 2'd1;
   localparam logic [1:0] c_wd_pc  = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEMACC = 3'd3,
      S_WB     = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      CL_RTYPE   = 4'd0,
      CL_IARITH  = 4'd1,
      CL_LOAD    = 4'd2,
      CL_STORE   = 4'd3,
      CL_BEQ     = 4'd4,
      CL_BNE     = 4'd5,
      CL_J       = 4'd6,
      CL_JAL     = 4'd7,
      CL_JR      = 4'd8,
      CL_ILLEGAL = 4'd9
   } instr_class_t;

   // States in which a memory access is outstanding and may have to wait.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMACC);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_decode.sv
// ============================================================================
//  Module   : mc_decode
//  Purpose  : Combinational op/funct decoder: instruction class plus ALU/EXT
//             controls for the multi-cycle sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_decode
   import mc_control_pkg::*;
#(
   parameter int ALUOP_W = 5
) (
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   output instr_class_t       iclass,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [1:0]         ext_op,
   output logic               alu_src_b
);

   logic [4:0] w_alu_code;

   always_comb begin
      iclass     = CL_ILLEGAL;
      w_alu_code = c_alu_add;
      ext_op     = c_ext_zero;
      alu_src_b  = 1'b0;
      case (op)
         c_op_rtype: begin
            iclass = CL_RTYPE;
            case (funct)
               c_fn_addu: w_alu_code = c_alu_add;
               c_fn_subu: w_alu_code = c_alu_sub;
               c_fn_and:  w_alu_code = c_alu_and;
               c_fn_or:   w_alu_code = c_alu_or;
               c_fn_xor:  w_alu_code = c_alu_xor;
               c_fn_nor:  w_alu_code = c_alu_nor;
               c_fn_slt:  w_alu_code = c_alu_slt;
               c_fn_sltu: w_alu_code = c_alu_sltu;
               c_fn_jr:   iclass     = CL_JR;
               default:   iclass     = CL_ILLEGAL;
            endcase
         end
         c_op_j:   iclass = CL_J;
         c_op_jal: iclass = CL_JAL;
         c_op_beq, c_op_bne: begin
            iclass     = (op == c_op_beq) ? CL_BEQ : CL_BNE;
            w_alu_code = c_alu_sub;
            ext_op     = c_ext_sign;
         end
         c_op_addiu: begin
            iclass     = CL_IARITH;
            w_alu_code = c_alu_add;
            ext_op     = c_ext_sign;
            alu_src_b  = 1'b1;
         end
         c_op_slti: begin
            iclass     = CL_IARITH;
            w_alu_code = c_alu_slt;
            ext_op     = c_ext_sign;
            alu_src_b  = 1'b1;
         end
         c_op_ori: begin
            iclass     = CL_IARITH;
            w_alu_code = c_alu_or;
            ext_op     = c_ext_zero;
            alu_src_b  = 1'b1;
         end
         c_op_lui: begin
            iclass     = CL_IARITH;
            w_alu_code = c_alu_lui;
            ext_op     = c_ext_lui;
            alu_src_b  = 1'b1;
         end
         c_op_lw, c_op_sw: begin
            iclass     = (op == c_op_lw) ? CL_LOAD : CL_STORE;
            w_alu_code = c_alu_add;
            ext_op     = c_ext_sign;
            alu_src_b  = 1'b1;
         end
         default: iclass = CL_ILLEGAL;
      endcase
   end

   assign alu_op = ALUOP_W'(w_alu_code);

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
//  Module   : mc_control
//  Purpose  : Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEMACC/WB).
//             Optional memory-wait handshake enabled by MC_MEMWAIT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control
   import mc_control_pkg::*;
#(
   parameter int ALUOP_W = 5,
   parameter int WAIT_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_we,
   output logic [1:0]         npc_op,
   output logic               ir_we,
   output logic               iord,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic               rf_we,
   output logic [1:0]         reg_dst,
   output logic [1:0]         wd_sel,
   output logic               alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [1:0]         ext_op,
   output logic [2:0]         state,
   output logic               illegal,
   output logic               mem_err
);

   state_t       r_state;
   logic         r_illegal;
   logic         r_mem_err;
   instr_class_t w_class;
   logic         w_mem_ok;
   logic         w_timeout;

   // IR holds op/funct for the whole instruction, so the EXEC-cycle ALU/EXT
   // controls stay stable through MEMACC and WB without extra registers.
   mc_decode #(
      .ALUOP_W (ALUOP_W)
   ) u_decode (
      .op        (op),
      .funct     (funct),
      .iclass    (w_class),
      .alu_op    (alu_op),
      .ext_op    (ext_op),
      .alu_src_b (alu_src_b)
   );

`ifdef MC_MEMWAIT_EN
   localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'((2 ** WAIT_W) - 2);

   logic [WAIT_W-1:0] r_wait_cnt;

   assign w_mem_ok  = mem_ready;
   assign w_timeout = !mem_ready && (r_wait_cnt == c_wait_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (!is_mem_state(r_state) || mem_ready || w_timeout) begin
         r_wait_cnt <= '0;
      end else begin
         r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
   end
`else
   logic [WAIT_W:0] unused_cfg;

   assign unused_cfg = {{WAIT_W{1'b0}}, mem_ready};
   assign w_mem_ok   = 1'b1;
   assign w_timeout  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
         r_mem_err <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         r_mem_err <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (w_mem_ok) begin
                  r_state <= S_DECODE;
               end else if (w_timeout) begin
                  r_state   <= S_FETCH;
                  r_mem_err <= 1'b1;
               end
            end
            S_DECODE: begin
               case (w_class)
                  CL_J, CL_JAL: r_state <= S_FETCH;
                  CL_ILLEGAL: begin
                     r_state   <= S_FETCH;
                     r_illegal <= 1'b1;
                  end
                  default:      r_state <= S_EXEC;
               endcase
            end
            S_EXEC: begin
               case (w_class)
                  CL_LOAD, CL_STORE:  r_state <= S_MEMACC;
                  CL_RTYPE, CL_IARITH: r_state <= S_WB;
                  default:            r_state <= S_FETCH;
               endcase
            end
            S_MEMACC: begin
               if (w_mem_ok) begin
                  r_state <= (w_class == CL_LOAD) ? S_WB : S_FETCH;
               end else if (w_timeout) begin
                  r_state   <= S_FETCH;
                  r_mem_err <= 1'b1;
               end
            end
            S_WB:    r_state <= S_FETCH;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_we   = 1'b0;
      npc_op  = c_npc_plus4;
      ir_we   = 1'b0;
      iord    = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      rf_we   = 1'b0;
      reg_dst = c_dst_rt;
      wd_sel  = c_wd_alu;
      case (r_state)
         S_FETCH: begin
            mem_rd = 1'b1;
            ir_we  = w_mem_ok;
            pc_we  = w_mem_ok;
         end
         S_DECODE: begin
            if (w_class == CL_J || w_class == CL_JAL) begin
               pc_we  = 1'b1;
               npc_op = c_npc_jump;
            end
            if (w_class == CL_JAL) begin
               rf_we   = 1'b1;
               reg_dst = c_dst_r31;
               wd_sel  = c_wd_pc;
            end
         end
         S_EXEC: begin
            case (w_class)
               CL_BEQ: begin
                  pc_we  = zero;
                  npc_op = c_npc_branch;
               end
               CL_BNE: begin
                  pc_we  = ~zero;
                  npc_op = c_npc_branch;
               end
               CL_JR: begin
                  pc_we  = 1'b1;
                  npc_op = c_npc_jr;
               end
               default: ;
            endcase
         end
         S_MEMACC: begin
            iord   = 1'b1;
            mem_rd = (w_class == CL_LOAD);
            mem_wr = (w_class == CL_STORE) && w_mem_ok;
         end
         S_WB: begin
            rf_we = 1'b1;
            if (w_class == CL_RTYPE) begin
               reg_dst = c_dst_rd;
            end else if (w_class == CL_LOAD) begin
               wd_sel = c_wd_mem;
            end
         end
         default: ;
      endcase
      // Reset must kill every write strobe immediately, not at the next edge.
      if (rst) begin
         pc_we  = 1'b0;
         ir_we  = 1'b0;
         mem_rd = 1'b0;
         mem_wr = 1'b0;
         rf_we  = 1'b0;
      end
   end

   assign state   = r_state;
   assign illegal = r_illegal;
   assign mem_err = r_mem_err;

endmodule

`default_nettype wire
